// File: rtl/ddrphy_lanectrl_dly_seq_if.sv
// Command handshake between training logic and the delay-line sequencer.
// Master drives the request; slave returns CMD_READY.
interface ddrphy_lanectrl_dly_seq_if;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [1:0] CMD_OP;
    logic       CMD_SEL;
    logic [7:0] CMD_COUNT;

    modport master (
        output CMD_VALID,
        output CMD_OP,
        output CMD_SEL,
        output CMD_COUNT,
        input  CMD_READY
    );

    modport slave (
        input  CMD_VALID,
        input  CMD_OP,
        input  CMD_SEL,
        input  CMD_COUNT,
        output CMD_READY
    );
endinterface

// File: rtl/ddrphy_lanectrl_dly_seq.sv
// LANECTRL delay-line sequencer: wraps LOAD/MOVE strobes in an
// HS_IO_CLK pause window and keeps shadow RX/TX tap counts.
module ddrphy_lanectrl_dly_seq #(
    parameter int         PAUSE_PRE_CYC  = 4,
    parameter int         PAUSE_POST_CYC = 4,
    parameter int         MOVE_GAP       = 3,
    parameter logic [7:0] RESET_TAP      = 8'd1
) (
    input  logic                            CLK,
    input  logic                            RESET_N,
    ddrphy_lanectrl_dly_seq_if.slave        cmd,
    input  logic                            RX_OOR,
    input  logic                            TX_OOR,
    output logic                            DELAY_LINE_SEL,
    output logic                            DELAY_LINE_LOAD,
    output logic                            DELAY_LINE_DIRECTION,
    output logic                            DELAY_LINE_MOVE,
    output logic                            HS_IO_CLK_PAUSE,
    output logic [7:0]                      RX_TAP,
    output logic [7:0]                      TX_TAP,
    output logic                            DONE,
    output logic                            ERR_OOR
);

    localparam logic [3:0] PRE_LD  = 4'(PAUSE_PRE_CYC - 1);
    localparam logic [3:0] POST_LD = 4'(PAUSE_POST_CYC - 1);
    localparam logic [3:0] GAP_LD  = 4'(MOVE_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_STROBE,
        ST_GAP,
        ST_POST,
        ST_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] rem_q, rem_d;
    logic       load_op_q, load_op_d;
    logic       sel_q, sel_d;
    logic       dir_q, dir_d;
    logic       err_q, err_d;
    logic [7:0] rx_tap_q, rx_tap_d;
    logic [7:0] tx_tap_q, tx_tap_d;
    logic       ready_q, load_q, move_q, pause_q, done_q;
    logic       is_load, oor_sel;
    logic [7:0] cur_tap, nxt_tap;

    assign is_load = (cmd.CMD_OP == 2'b00) || (cmd.CMD_OP == 2'b11);
    assign oor_sel = sel_q ? TX_OOR : RX_OOR;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        load_op_d = load_op_q;
        sel_d     = sel_q;
        dir_d     = dir_q;
        err_d     = err_q;
        rx_tap_d  = rx_tap_q;
        tx_tap_d  = tx_tap_q;
        cur_tap   = sel_q ? tx_tap_q : rx_tap_q;
        nxt_tap   = cur_tap;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd.CMD_VALID) begin
                    err_d     = 1'b0;
                    sel_d     = cmd.CMD_SEL;
                    load_op_d = is_load;
                    if (cmd.CMD_OP == 2'b01) dir_d = 1'b1;
                    if (cmd.CMD_OP == 2'b10) dir_d = 1'b0;
                    rem_d = is_load ? 8'd1 : cmd.CMD_COUNT;
                    if (!is_load && cmd.CMD_COUNT == 8'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_PRE;
                        cnt_d   = PRE_LD;
                    end
                end
            end
            ST_PRE: begin
                if (cnt_q == 4'd0) state_d = ST_STROBE;
                else cnt_d = cnt_q - 4'd1;
            end
            ST_STROBE: begin
                if (load_op_q) nxt_tap = RESET_TAP;
                else if (dir_q) nxt_tap = (cur_tap == 8'hFF) ? cur_tap : cur_tap + 8'd1;
                else nxt_tap = (cur_tap == 8'h00) ? cur_tap : cur_tap - 8'd1;
                if (sel_q) tx_tap_d = nxt_tap;
                else rx_tap_d = nxt_tap;
                rem_d   = rem_q - 8'd1;
                cnt_d   = GAP_LD;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (oor_sel || rem_q == 8'd0) begin
                    // an out-of-range line abandons the remaining moves
                    err_d   = err_q | oor_sel;
                    cnt_d   = POST_LD;
                    state_d = ST_POST;
                end else begin
                    state_d = ST_STROBE;
                end
            end
            ST_POST: begin
                if (cnt_q == 4'd0) state_d = ST_DONE;
                else cnt_d = cnt_q - 4'd1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            rem_q     <= 8'd0;
            load_op_q <= 1'b0;
            sel_q     <= 1'b0;
            dir_q     <= 1'b1;
            err_q     <= 1'b0;
            rx_tap_q  <= RESET_TAP;
            tx_tap_q  <= RESET_TAP;
            ready_q   <= 1'b1;
            load_q    <= 1'b0;
            move_q    <= 1'b0;
            pause_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            load_op_q <= load_op_d;
            sel_q     <= sel_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            rx_tap_q  <= rx_tap_d;
            tx_tap_q  <= tx_tap_d;
            // strobes and pause are registered from the next state
            ready_q   <= (state_d == ST_IDLE);
            load_q    <= (state_d == ST_STROBE) && load_op_d;
            move_q    <= (state_d == ST_STROBE) && !load_op_d;
            pause_q   <= (state_d == ST_PRE) || (state_d == ST_STROBE)
                      || (state_d == ST_GAP) || (state_d == ST_POST);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign cmd.CMD_READY          = ready_q;
    assign DELAY_LINE_SEL         = sel_q;
    assign DELAY_LINE_LOAD        = load_q;
    assign DELAY_LINE_DIRECTION   = dir_q;
    assign DELAY_LINE_MOVE        = move_q;
    assign HS_IO_CLK_PAUSE        = pause_q;
    assign RX_TAP                 = rx_tap_q;
    assign TX_TAP                 = tx_tap_q;
    assign DONE                   = done_q;
    assign ERR_OOR                = err_q;

endmodule

// File: tb/tb_ddrphy_lanectrl_dly_seq.sv
// Directed bench for the LANECTRL delay-line sequencer.
// Cycle 1 is the cycle right after the accept edge.
module tb_ddrphy_lanectrl_dly_seq;

    logic       CLK;
    logic       RESET_N;
    logic       RX_OOR, TX_OOR;
    logic       SEL, LOAD, DIR, MOVE, PAUSE, DONE, ERR;
    logic [7:0] RX_TAP, TX_TAP;

    ddrphy_lanectrl_dly_seq_if cmd_if();

    ddrphy_lanectrl_dly_seq dut (
        .CLK                  (CLK),
        .RESET_N              (RESET_N),
        .cmd                  (cmd_if.slave),
        .RX_OOR               (RX_OOR),
        .TX_OOR               (TX_OOR),
        .DELAY_LINE_SEL       (SEL),
        .DELAY_LINE_LOAD      (LOAD),
        .DELAY_LINE_DIRECTION (DIR),
        .DELAY_LINE_MOVE      (MOVE),
        .HS_IO_CLK_PAUSE      (PAUSE),
        .RX_TAP               (RX_TAP),
        .TX_TAP               (TX_TAP),
        .DONE                 (DONE),
        .ERR_OOR              (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int         checks;
    int         failures;
    logic [7:0] rx_hist [0:127];
    logic [7:0] tx_hist [0:127];
    int         mv_cyc[$];
    int         done_at, n_load, load_cyc, pause_cnt;
    bit         sel_bad, dir_bad;

    task automatic wait_ready();
        int w;
        w = 0;
        while (!cmd_if.CMD_READY && w < 50) begin
            @(posedge CLK); #1;
            w++;
        end
        checks++;
        if (!cmd_if.CMD_READY) begin
            $display("FAIL ready_timeout got=0 exp=1");
            failures++;
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic sel,
                           input logic [7:0] cnt, input logic exp_dir,
                           input int oor_after, input int stop_at);
        mv_cyc.delete();
        done_at = -1; n_load = 0; load_cyc = -1; pause_cnt = 0;
        sel_bad = 0; dir_bad = 0;
        wait_ready();
        cmd_if.CMD_VALID = 1'b1;
        cmd_if.CMD_OP    = op;
        cmd_if.CMD_SEL   = sel;
        cmd_if.CMD_COUNT = cnt;
        @(posedge CLK); #1;
        cmd_if.CMD_VALID = 1'b0;
        for (int c = 1; c <= 120; c++) begin
            rx_hist[c] = RX_TAP;
            tx_hist[c] = TX_TAP;
            if (PAUSE) pause_cnt++;
            if (LOAD) begin n_load++; load_cyc = c; end
            if (SEL !== sel) sel_bad = 1;
            if (DIR !== exp_dir) dir_bad = 1;
            if (MOVE) begin
                mv_cyc.push_back(c);
                if (mv_cyc.size() == oor_after) begin
                    if (sel) TX_OOR = 1'b1;
                    else RX_OOR = 1'b1;
                end
            end
            if (DONE) begin done_at = c; break; end
            if (c == stop_at) break;
            @(posedge CLK); #1;
        end
        RX_OOR = 1'b0;
        TX_OOR = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (cmd_if.CMD_READY !== 1'b1) begin $display("FAIL rst_ready got=%b exp=1", cmd_if.CMD_READY); failures++; end
        checks++; if ({DONE, ERR, PAUSE, LOAD, MOVE, SEL} !== 6'b0) begin
            $display("FAIL rst_ctrl got=%b exp=000000", {DONE, ERR, PAUSE, LOAD, MOVE, SEL}); failures++; end
        checks++; if (DIR !== 1'b1) begin $display("FAIL rst_dir got=%b exp=1", DIR); failures++; end
        checks++; if (RX_TAP !== 8'd1 || TX_TAP !== 8'd1) begin
            $display("FAIL rst_taps got=%0d/%0d exp=1/1", RX_TAP, TX_TAP); failures++; end
    endtask

    task automatic test_load_rx();
        run_cmd(2'b00, 1'b0, 8'd0, 1'b1, 0, 0);
        checks++; if (done_at !== 13) begin $display("FAIL load_done got=%0d exp=13", done_at); failures++; end
        checks++; if (n_load !== 1 || load_cyc !== 5) begin
            $display("FAIL load_strobe got=n%0d@%0d exp=n1@5", n_load, load_cyc); failures++; end
        checks++; if (mv_cyc.size() !== 0) begin $display("FAIL load_moves got=%0d exp=0", mv_cyc.size()); failures++; end
        checks++; if (pause_cnt !== 12 || PAUSE !== 1'b0) begin
            $display("FAIL load_pause got=%0d,%b exp=12,0", pause_cnt, PAUSE); failures++; end
        checks++; if (RX_TAP !== 8'd1 || sel_bad) begin $display("FAIL load_tap got=%0d exp=1", RX_TAP); failures++; end
    endtask

    task automatic test_move_tx_inc();
        run_cmd(2'b01, 1'b1, 8'd3, 1'b1, 0, 0);
        checks++; if (done_at !== 21) begin $display("FAIL inc_done got=%0d exp=21", done_at); failures++; end
        checks++; if (mv_cyc.size() !== 3 || mv_cyc[0] !== 5 || mv_cyc[1] !== 9 || mv_cyc[2] !== 13) begin
            $display("FAIL inc_moves got=n%0d first=%0d exp=n3 5/9/13", mv_cyc.size(), mv_cyc[0]); failures++; end
        checks++; if (tx_hist[5] !== 8'd1 || tx_hist[6] !== 8'd2) begin
            $display("FAIL inc_tap_edge got=%0d,%0d exp=1,2", tx_hist[5], tx_hist[6]); failures++; end
        checks++; if (TX_TAP !== 8'd4 || RX_TAP !== 8'd1) begin
            $display("FAIL inc_tap got=%0d/%0d exp=4/1", TX_TAP, RX_TAP); failures++; end
        checks++; if (ERR !== 1'b0 || sel_bad || dir_bad || n_load !== 0) begin
            $display("FAIL inc_flags got=err%b sel%0d dir%0d ld%0d exp=0", ERR, sel_bad, dir_bad, n_load); failures++; end
        checks++; if (pause_cnt !== 20) begin $display("FAIL inc_pause got=%0d exp=20", pause_cnt); failures++; end
    endtask

    task automatic test_move_rx_dec_oor();
        run_cmd(2'b10, 1'b0, 8'd5, 1'b0, 2, 0);
        checks++; if (done_at !== 17) begin $display("FAIL dec_done got=%0d exp=17", done_at); failures++; end
        checks++; if (mv_cyc.size() !== 2 || mv_cyc[1] !== 9) begin
            $display("FAIL dec_moves got=%0d exp=2", mv_cyc.size()); failures++; end
        checks++; if (rx_hist[6] !== 8'd0 || rx_hist[10] !== 8'd0 || RX_TAP !== 8'd0) begin
            $display("FAIL dec_sat got=%0d,%0d,%0d exp=0,0,0", rx_hist[6], rx_hist[10], RX_TAP); failures++; end
        checks++; if (ERR !== 1'b1 || dir_bad || sel_bad) begin
            $display("FAIL dec_err got=err%b dir%0d sel%0d exp=1,0,0", ERR, dir_bad, sel_bad); failures++; end
        @(posedge CLK); #1;
        checks++; if (ERR !== 1'b1) begin $display("FAIL dec_sticky got=%b exp=1", ERR); failures++; end
    endtask

    task automatic test_move_zero();
        run_cmd(2'b01, 1'b1, 8'd0, 1'b1, 0, 0);
        checks++; if (done_at !== 1) begin $display("FAIL zero_done got=%0d exp=1", done_at); failures++; end
        checks++; if (pause_cnt !== 0 || mv_cyc.size() !== 0 || n_load !== 0) begin
            $display("FAIL zero_activity got=p%0d m%0d l%0d exp=0", pause_cnt, mv_cyc.size(), n_load); failures++; end
        checks++; if (TX_TAP !== 8'd4 || RX_TAP !== 8'd0) begin
            $display("FAIL zero_taps got=%0d/%0d exp=4/0", TX_TAP, RX_TAP); failures++; end
        checks++; if (ERR !== 1'b0) begin $display("FAIL zero_errclr got=%b exp=0", ERR); failures++; end
    endtask

    task automatic test_reset_mid_op();
        run_cmd(2'b01, 1'b0, 8'd4, 1'b1, 0, 11);
        checks++; if (PAUSE !== 1'b1 || RX_TAP !== 8'd2 || mv_cyc.size() !== 2) begin
            $display("FAIL mid_pre got=p%b tap%0d m%0d exp=1,2,2", PAUSE, RX_TAP, mv_cyc.size()); failures++; end
        RESET_N = 1'b0;
        #1;
        checks++; if (PAUSE !== 1'b0 || MOVE !== 1'b0 || LOAD !== 1'b0 || DONE !== 1'b0) begin
            $display("FAIL mid_async got=%b%b%b%b exp=0000", PAUSE, MOVE, LOAD, DONE); failures++; end
        checks++; if (RX_TAP !== 8'd1 || TX_TAP !== 8'd1 || cmd_if.CMD_READY !== 1'b1) begin
            $display("FAIL mid_state got=%0d/%0d rdy%b exp=1/1 rdy1", RX_TAP, TX_TAP, cmd_if.CMD_READY); failures++; end
        #1;
        RESET_N = 1'b1;
        @(posedge CLK); #1;
        run_cmd(2'b00, 1'b1, 8'd0, 1'b1, 0, 0);
        checks++; if (done_at !== 13 || n_load !== 1 || TX_TAP !== 8'd1) begin
            $display("FAIL mid_reload got=d%0d l%0d tap%0d exp=13,1,1", done_at, n_load, TX_TAP); failures++; end
    endtask

    task automatic test_back_to_back();
        int         d1, d2;
        logic [7:0] rx_mid;
        logic       err_mid;
        d1 = -1; d2 = -1; rx_mid = 8'hxx; err_mid = 1'bx;
        wait_ready();
        cmd_if.CMD_VALID = 1'b1;
        cmd_if.CMD_OP    = 2'b01;
        cmd_if.CMD_SEL   = 1'b0;
        cmd_if.CMD_COUNT = 8'd2;
        RX_OOR = 1'b0;
        TX_OOR = 1'b1;
        @(posedge CLK); #1;
        cmd_if.CMD_OP    = 2'b00;
        cmd_if.CMD_COUNT = 8'd0;
        for (int c = 1; c <= 60; c++) begin
            TX_OOR = ~TX_OOR;
            if (d1 < 0 && DONE) begin
                d1 = c; rx_mid = RX_TAP; err_mid = ERR;
                checks++; if (cmd_if.CMD_READY !== 1'b0) begin $display("FAIL b2b_rdy_done got=1 exp=0"); failures++; end
            end else if (d1 > 0 && c == d1 + 1) begin
                checks++; if (cmd_if.CMD_READY !== 1'b1) begin $display("FAIL b2b_rdy_gap got=0 exp=1"); failures++; end
            end else if (d1 > 0 && c == d1 + 2) begin
                checks++; if (cmd_if.CMD_READY !== 1'b0 || PAUSE !== 1'b1) begin
                    $display("FAIL b2b_accept2 got=rdy%b p%b exp=rdy0 p1", cmd_if.CMD_READY, PAUSE); failures++; end
                cmd_if.CMD_VALID = 1'b0;
            end else if (d1 > 0 && DONE) begin
                d2 = c;
                break;
            end
            @(posedge CLK); #1;
        end
        cmd_if.CMD_VALID = 1'b0;
        TX_OOR = 1'b0;
        checks++; if (d1 !== 17 || d2 !== 31) begin $display("FAIL b2b_done got=%0d,%0d exp=17,31", d1, d2); failures++; end
        checks++; if (rx_mid !== 8'd3 || err_mid !== 1'b0) begin
            $display("FAIL b2b_cmd1 got=tap%0d err%b exp=3,0", rx_mid, err_mid); failures++; end
        checks++; if (RX_TAP !== 8'd1 || ERR !== 1'b0) begin
            $display("FAIL b2b_cmd2 got=tap%0d err%b exp=1,0", RX_TAP, ERR); failures++; end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RESET_N  = 1'b0;
        RX_OOR   = 1'b0;
        TX_OOR   = 1'b0;
        cmd_if.CMD_VALID = 1'b0;
        cmd_if.CMD_OP    = 2'b00;
        cmd_if.CMD_SEL   = 1'b0;
        cmd_if.CMD_COUNT = 8'd0;
        repeat (3) @(posedge CLK);
        #2 RESET_N = 1'b1;
        @(posedge CLK); #1;
        test_reset();
        test_load_rx();
        test_move_tx_inc();
        test_move_rx_dec_oor();
        test_move_zero();
        test_reset_mid_op();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
